ld_mem_sched: RTL and testbench
===============================

Name: ld_mem_sched

Overview:
Sequences the single-port, synchronous-read data memory that feeds the load stage's two operand bytes (mem_data_1 and mem_data_2).
- Each load needs two reads, so the block issues them back-to-back and holds the pipeline with freeze until both bytes are ready.
- It arbitrates the same port against store writes from writeback.
- It latches the halt condition and stops all further loads.

Parameters:
ADDR_W, 8, data memory address width
DATA_W, 8, data memory word width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  load stage requests an operand pair
req_adr_1  in  ADDR_W  address of operand 1
req_adr_2  in  ADDR_W  address of operand 2
req_halt  in  1  qualifies req_valid: halt instruction, no reads
wb_write  in  1  writeback store request
wb_adr  in  ADDR_W  store address
wb_data  in  DATA_W  store data
wb_ready  out  1  store accepted this cycle
mem_adr  out  ADDR_W  memory address (combinational from state and inputs)
mem_we  out  1  memory write enable
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  read data, valid the cycle after the address
freeze  out  1  stall the upstream pipeline
op_valid  out  1  one-cycle pulse: data_out_1/2 valid
data_out_1  out  DATA_W  registered operand 1
data_out_2  out  DATA_W  registered operand 2
halted  out  1  sticky halt flag

Behaviour:
- Reset values:
  - State IDLE.
  - freeze=0, op_valid=0, halted=0, data_out_1/2=0, wb_ready=0.
  - mem_we=0, mem_adr=0, mem_wdata=0.
- Reset mid-sequence abandons the load; no op_valid is produced.
- States: IDLE, RD1, RD2, DONE, HALT.
- IDLE:
  - wb_write has priority. It drives mem_we=1, mem_adr=wb_adr, mem_wdata=wb_data and wb_ready=1. State stays IDLE, and a pending req_valid waits (freeze=1 that cycle).
  - Otherwise, req_valid with req_halt=1 sets halted=1 and moves to HALT. No memory access occurs.
  - Otherwise, req_valid with req_halt=0 drives mem_adr=req_adr_1 and moves to RD1. req_adr_2 is latched internally. freeze=1.
- RD1:
  - Drives mem_adr=latched adr_2.
  - Captures data_out_1<=mem_rdata.
  - Moves to RD2. freeze=1.
- RD2:
  - Captures data_out_2<=mem_rdata.
  - Moves to DONE. freeze=1.
- DONE:
  - op_valid=1, freeze=0.
  - Returns to IDLE.
  - DONE does not accept a new request or write; wb_ready=0.
- Load latency: request accepted in cycle t gives op_valid in cycle t+3. Back-to-back loads therefore run at one per 4 cycles.
- Writes and reads:
  - wb_write during RD1/RD2/DONE gets wb_ready=0 and must be held by writeback.
  - A read of an address written earlier returns the new data; there is no forwarding inside this block.
- Same-address case: req_adr_1==req_adr_2 still performs two reads.
- data_out_1/2 hold their values until the next capture.
- HALT:
  - halted stays 1 until reset; freeze=0.
  - req_valid is ignored; no reads are issued.
  - wb_write is still serviced exactly as in IDLE, so in-flight stores drain.
- mem_we is never 1 outside a wb_ready=1 cycle.
- freeze is also asserted in IDLE whenever req_valid=1 and wb_write=1. Otherwise freeze=0 in IDLE.

Decomposition:
- Shared package holds:
  - state enum: IDLE, RD1, RD2, DONE, HALT;
  - ADDR_W/DATA_W defaults;
  - LD_LATENCY=3 constant for benches.
- The design is a single module with no sub-module. The operand capture registers are simple enough to stay inline.

Test Plan:
- Load path: memory[0x10]=0xA5, memory[0x11]=0x3C; req_valid with adr_1=0x10, adr_2=0x11 at t -> freeze high in t..t+2, op_valid only in t+3, data_out_1=0xA5, data_out_2=0x3C.
- Write priority: wb_write (adr 0x20, data 0x77) together with req_valid (adr_1=0x20, adr_2=0x21) -> write done at t (wb_ready=1), read starts t+1, data_out_1=0x77, op_valid at t+4.
- Write during read: wb_write asserted in RD1 -> wb_ready=0 through RD1/RD2/DONE, write accepted on the first IDLE cycle, mem_we pulses exactly once.
- Halt: req_valid+req_halt -> halted=1 next cycle and stays; later req_valid gives no mem_adr change or op_valid; wb_write (0x05, 0xEE) is still accepted and memory[0x05]=0xEE.
- Reset in RD2: reset asserted -> next cycle state IDLE, freeze=0, data_out_1/2=0, no op_valid pulse.
- Same-address load: adr_1=adr_2=0x30, memory[0x30]=0x42 -> data_out_1=data_out_2=0x42, two read cycles observed on mem_adr.

Source files
------------

// File: rtl/ld_mem_sched_pkg.sv
// Shared types and defaults for the load-stage data memory sequencer.
// The state enum, the default widths and the load latency live here so the design and its bench agree.
package ld_mem_sched_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    // Cycles from request acceptance to the op_valid pulse.
    localparam int LD_LATENCY = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD1  = 3'd1,
        ST_RD2  = 3'd2,
        ST_DONE = 3'd3,
        ST_HALT = 3'd4
    } state_e;

endpackage

// File: rtl/ld_mem_sched.sv
// Load-stage memory sequencer: issues two back-to-back reads per load on a single-port
// synchronous-read memory, arbitrates store writes, and latches the halt condition.
module ld_mem_sched
    import ld_mem_sched_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_adr_1,
    input  logic [ADDR_W-1:0] req_adr_2,
    input  logic              req_halt,
    input  logic              wb_write,
    input  logic [ADDR_W-1:0] wb_adr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_ready,
    output logic [ADDR_W-1:0] mem_adr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              freeze,
    output logic              op_valid,
    output logic [DATA_W-1:0] data_out_1,
    output logic [DATA_W-1:0] data_out_2,
    output logic              halted
);

    state_e            state_reg, state_next;
    logic [ADDR_W-1:0] adr_2_reg, adr_2_next;
    logic              halted_reg, halted_next;
    logic [DATA_W-1:0] data_1_reg, data_2_reg;

    // IDLE and HALT both own the port for stores; only IDLE may start loads.
    logic port_free;
    assign port_free = (state_reg == ST_IDLE) || (state_reg == ST_HALT);

    always_comb begin
        state_next  = state_reg;
        adr_2_next  = adr_2_reg;
        halted_next = halted_reg;
        mem_adr     = '0;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        wb_ready    = 1'b0;
        freeze      = 1'b0;
        op_valid    = 1'b0;

        if (port_free && wb_write) begin
            mem_we    = 1'b1;
            mem_adr   = wb_adr;
            mem_wdata = wb_data;
            wb_ready  = 1'b1;
            // A load colliding with a store is held off for this cycle.
            freeze    = (state_reg == ST_IDLE) && req_valid;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid && req_halt) begin
                        halted_next = 1'b1;
                        state_next  = ST_HALT;
                    end else if (req_valid) begin
                        mem_adr    = req_adr_1;
                        adr_2_next = req_adr_2;
                        freeze     = 1'b1;
                        state_next = ST_RD1;
                    end
                end
                ST_RD1: begin
                    mem_adr    = adr_2_reg;
                    freeze     = 1'b1;
                    state_next = ST_RD2;
                end
                ST_RD2: begin
                    freeze     = 1'b1;
                    state_next = ST_DONE;
                end
                ST_DONE: begin
                    op_valid   = 1'b1;
                    state_next = ST_IDLE;
                end
                ST_HALT: begin
                    state_next = ST_HALT;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            adr_2_reg  <= '0;
            halted_reg <= 1'b0;
            data_1_reg <= '0;
            data_2_reg <= '0;
        end else begin
            state_reg  <= state_next;
            adr_2_reg  <= adr_2_next;
            halted_reg <= halted_next;
            // Read data arrives one cycle after its address was presented.
            if (state_reg == ST_RD1) begin
                data_1_reg <= mem_rdata;
            end
            if (state_reg == ST_RD2) begin
                data_2_reg <= mem_rdata;
            end
        end
    end

    assign data_out_1 = data_1_reg;
    assign data_out_2 = data_2_reg;
    assign halted     = halted_reg;

endmodule

// File: tb/tb_ld_mem_sched.sv
// Bench for ld_mem_sched: directed scenarios then random traffic, checked against a
// transaction-level model (countdown of remaining load cycles plus a reference memory).
module tb_ld_mem_sched;
    import ld_mem_sched_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_halt, wb_write;
    logic [7:0] req_adr_1, req_adr_2, wb_adr, wb_data;
    logic       wb_ready, mem_we, freeze, op_valid, halted;
    logic [7:0] mem_adr, mem_wdata, mem_rdata, data_out_1, data_out_2;

    always #5 clk = ~clk;

    ld_mem_sched #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_adr_1(req_adr_1), .req_adr_2(req_adr_2), .req_halt(req_halt),
        .wb_write(wb_write), .wb_adr(wb_adr), .wb_data(wb_data), .wb_ready(wb_ready),
        .mem_adr(mem_adr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .freeze(freeze), .op_valid(op_valid),
        .data_out_1(data_out_1), .data_out_2(data_out_2), .halted(halted)
    );

    // Environment memory: single port, synchronous read, written only by the DUT.
    logic [7:0] mem [256];
    int         we_cnt = 0;
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_adr] <= mem_wdata;
            we_cnt       <= we_cnt + 1;
        end
        mem_rdata <= mem[mem_adr];
    end

    // Reference model state.
    logic [7:0] ref_mem [256];
    int         busy = 0;        // cycles left in the current load, 0 when the port is free
    bit         m_halted = 1'b0;
    logic [7:0] pa1 = 8'h00, pa2 = 8'h00, m_d1 = 8'h00, m_d2 = 8'h00;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
    task automatic step(input bit rst, input bit rv, input bit rh, input logic [7:0] a1,
                        input logic [7:0] a2, input bit ww, input logic [7:0] wa, input logic [7:0] wd);
        bit         e_we, e_fr, e_ov, chk_adr;
        logic [7:0] e_adr;
        @(negedge clk);
        reset = rst; req_valid = rv; req_halt = rh; req_adr_1 = a1; req_adr_2 = a2;
        wb_write = ww; wb_adr = wa; wb_data = wd;
        #1;
        e_we = 1'b0; e_fr = 1'b0; e_ov = 1'b0; e_adr = 8'h00; chk_adr = 1'b1;
        case (busy)
            0: begin
                e_we = ww;
                e_fr = !m_halted && rv && (ww || !rh);
                if (ww) e_adr = wa;
                else if (!m_halted && rv && !rh) e_adr = a1;
            end
            3: begin e_fr = 1'b1; e_adr = pa2; end
            2: begin e_fr = 1'b1; chk_adr = 1'b0; end
            default: begin e_ov = 1'b1; chk_adr = 1'b0; end
        endcase
        if (!rst) begin
            check("mem_we", mem_we, e_we);
            check("wb_ready", wb_ready, e_we);
            check("freeze", freeze, e_fr);
            check("op_valid", op_valid, e_ov);
            check("halted", halted, m_halted);
            check("data_out_1", data_out_1, m_d1);
            check("data_out_2", data_out_2, m_d2);
            if (chk_adr) check("mem_adr", mem_adr, e_adr);
            if (e_we) check("mem_wdata", mem_wdata, wd);
            if (e_ov) $display("load %02h/%02h -> %02h %02h", pa1, pa2, data_out_1, data_out_2);
        end
        @(posedge clk);
        if (rst) begin
            busy = 0; m_halted = 1'b0; m_d1 = 8'h00; m_d2 = 8'h00;
        end else begin
            case (busy)
                0: begin
                    if (ww) ref_mem[wa] = wd;
                    else if (!m_halted && rv && rh) m_halted = 1'b1;
                    else if (!m_halted && rv) begin busy = LD_LATENCY; pa1 = a1; pa2 = a2; end
                end
                3: begin m_d1 = ref_mem[pa1]; busy = 2; end
                2: begin m_d2 = ref_mem[pa2]; busy = 1; end
                default: busy = 0;
            endcase
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        step(0, 0, 0, 8'h00, 8'h00, 1, a, d);
    endtask

    task automatic load(input logic [7:0] a1, input logic [7:0] a2);
        step(0, 1, 0, a1, a2, 0, 8'h00, 8'h00);
    endtask

    initial begin
        int w0;
        reset = 1'b1; req_valid = 1'b0; req_halt = 1'b0; wb_write = 1'b0;
        req_adr_1 = 8'h00; req_adr_2 = 8'h00; wb_adr = 8'h00; wb_data = 8'h00;

        step(1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        step(1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        idle(1);

        // Fill the whole memory through the store path.
        for (int i = 0; i < 256; i++) wr(8'(i), 8'($urandom));
        wr(8'h10, 8'hA5);
        wr(8'h11, 8'h3C);

        // Plain load: freeze for three cycles, op_valid on the fourth.
        load(8'h10, 8'h11);
        idle(3);
        check("load_d1", data_out_1, 8'hA5);
        check("load_d2", data_out_2, 8'h3C);

        // Store wins over a simultaneous load; the load follows.
        step(0, 1, 0, 8'h20, 8'h21, 1, 8'h20, 8'h77);
        load(8'h20, 8'h21);
        idle(3);
        check("wprio_d1", data_out_1, 8'h77);

        // Store held across a load is taken on the first free cycle, exactly once.
        w0 = we_cnt;
        load(8'h40, 8'h41);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 8'h00, 1, 8'h41, 8'h99);
        idle(1);
        check("held_we_count", 32'(we_cnt - w0), 32'd1);

        // Same address twice.
        wr(8'h30, 8'h42);
        load(8'h30, 8'h30);
        idle(3);
        check("same_d1", data_out_1, 8'h42);
        check("same_d2", data_out_2, 8'h42);

        // Reset during RD2 abandons the load.
        load(8'h10, 8'h11);
        idle(1);
        step(1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        idle(2);

        // Halt: loads ignored, stores still drain.
        step(0, 1, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        idle(1);
        load(8'h10, 8'h11);
        load(8'h10, 8'h11);
        step(0, 1, 0, 8'h10, 8'h11, 1, 8'h05, 8'hEE);
        idle(2);
        check("halt_store", mem[5], 8'hEE);

        step(1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        idle(1);

        // Random traffic on a small address window to force collisions.
        for (int i = 0; i < 4000; i++) begin
            bit rst, rv, rh, ww;
            rst = ($urandom_range(0, 99) < 2);
            rv  = !rst && ($urandom_range(0, 1) == 1);
            rh  = rv && ($urandom_range(0, 31) == 0);
            ww  = !rst && ($urandom_range(0, 9) < 3);
            step(rst, rv, rh, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                 ww, 8'($urandom_range(0, 15)), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
